// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared size encodings, store entry type and lane-steer helper
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_DOUBLE = 2'b11
  } store_size_e;

  localparam int MAX_ADDR_W = 64;
  localparam int MAX_DATA_W = 64;
  localparam int MAX_LANES  = MAX_DATA_W / 8;

  // Widest possible entry; callers slice down to their own bus widths.
  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] data;
    logic [MAX_LANES-1:0]  mask;
  } store_entry_t;

  // Aligns the address to the bus and places right-justified data on its lanes.
  // A double on a 4-lane bus degrades to a word store.
  function automatic store_entry_t lane_steer(
    input logic [1:0]            func3,
    input logic [MAX_ADDR_W-1:0] addr,
    input logic [MAX_DATA_W-1:0] wdata,
    input int                    lanes
  );
    store_entry_t e;
    logic [1:0]   sz;
    logic [2:0]   off;
    logic [2:0]   base;
    e    = '0;
    base = '0;
    sz   = func3;
    if (sz == SZ_DOUBLE && lanes < MAX_LANES) sz = SZ_WORD;
    off = addr[2:0] & 3'(lanes - 1);
    case (sz)
      SZ_BYTE: begin
        base   = off;
        e.data = {56'd0, wdata[7:0]} << {base, 3'b000};
        e.mask = 8'h01 << base;
      end
      SZ_HALF: begin
        base   = off & 3'b110;
        e.data = {48'd0, wdata[15:0]} << {base, 3'b000};
        e.mask = 8'h03 << base;
      end
      SZ_WORD: begin
        base   = off & 3'b100;
        e.data = {32'd0, wdata[31:0]} << {base, 3'b000};
        e.mask = 8'h0f << base;
      end
      default: begin
        e.data = wdata;
        e.mask = 8'hff;
      end
    endcase
    e.addr = addr & ~MAX_ADDR_W'(lanes - 1);
    return e;
  endfunction

endpackage

// File: rtl/store_buffer_unit_if.sv
// rtl/store_buffer_unit_if.sv - pipeline and data-memory signals of the store buffer (STORE_MISALIGN_TRAP_EN adds trap outputs)
interface store_buffer_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
);
  localparam int LANES = DATA_W / 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              st_valid_in;
  logic              st_ready_out;
  logic [1:0]        func3_in;
  logic [ADDR_W-1:0] iadder_in;
  logic [DATA_W-1:0] rs2_in;
  logic              dm_wr_req_out;
  logic              dm_ack_in;
  logic [ADDR_W-1:0] dm_addr_out;
  logic [DATA_W-1:0] dm_data_out;
  logic [LANES-1:0]  dm_wr_mask_out;
  logic              empty_out;
  logic [CNT_W-1:0]  count_out;
`ifdef STORE_MISALIGN_TRAP_EN
  logic              misaligned_out;
  logic [ADDR_W-1:0] misaligned_addr_out;
`endif

  modport slave (
    input  st_valid_in, func3_in, iadder_in, rs2_in, dm_ack_in,
`ifdef STORE_MISALIGN_TRAP_EN
    output misaligned_out, misaligned_addr_out,
`endif
    output st_ready_out, dm_wr_req_out, dm_addr_out, dm_data_out,
           dm_wr_mask_out, empty_out, count_out
  );

  modport master (
    output st_valid_in, func3_in, iadder_in, rs2_in, dm_ack_in,
`ifdef STORE_MISALIGN_TRAP_EN
    input  misaligned_out, misaligned_addr_out,
`endif
    input  st_ready_out, dm_wr_req_out, dm_addr_out, dm_data_out,
           dm_wr_mask_out, empty_out, count_out
  );

endinterface

// File: rtl/store_buf_fifo.sv
// rtl/store_buf_fifo.sv - generic DEPTH-entry FIFO with occupancy count
module store_buf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage needs no reset; reads are only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/store_buffer_unit.sv
// rtl/store_buffer_unit.sv - lane-steering store buffer draining to data memory (STORE_MISALIGN_TRAP_EN: trap misaligned stores)
module store_buffer_unit
  import store_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  store_buffer_unit_if.slave  bus
);

  localparam int LANES   = DATA_W / 8;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + DATA_W + LANES;

  store_entry_t        steer;
  logic [ENTRY_W-1:0]  push_entry;
  logic [ENTRY_W-1:0]  head_entry;
  logic                full;
  logic                empty;
  logic [CNT_W-1:0]    count;
  logic                accept;
  logic                push;
  logic                pop;
  logic                mis;
  logic                unused_steer_hi;

  assign steer = lane_steer(bus.func3_in, MAX_ADDR_W'(bus.iadder_in),
                            MAX_DATA_W'(bus.rs2_in), LANES);
  assign push_entry = {steer.addr[ADDR_W-1:0], steer.data[DATA_W-1:0],
                       steer.mask[LANES-1:0]};
  // Upper bits of the max-width entry are zero for narrow buses.
  assign unused_steer_hi = ^{steer.addr, steer.data, steer.mask};

`ifdef STORE_MISALIGN_TRAP_EN
  // Flag stores whose address is not a multiple of their size.
  always_comb begin
    mis = 1'b0;
    case (bus.func3_in)
      SZ_HALF:   mis = bus.iadder_in[0];
      SZ_WORD:   mis = |bus.iadder_in[1:0];
      SZ_DOUBLE: mis = |bus.iadder_in[2:0];
      default:   mis = 1'b0;
    endcase
  end

  // One-cycle trap pulse and the offending address, held until the next trap.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bus.misaligned_out      <= 1'b0;
      bus.misaligned_addr_out <= '0;
    end else begin
      bus.misaligned_out <= accept && mis;
      if (accept && mis) bus.misaligned_addr_out <= bus.iadder_in;
    end
  end
`else
  // Misaligned stores are simply aligned down by the steering helper.
  assign mis = 1'b0;
`endif

  // Ready depends only on registered occupancy, never on dm_ack_in.
  assign accept = bus.st_valid_in && !full;
  assign push   = accept && !mis;
  assign pop    = !empty && bus.dm_ack_in;

  store_buf_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign bus.st_ready_out  = !full;
  assign bus.dm_wr_req_out = !empty;
  assign bus.empty_out     = empty;
  assign bus.count_out     = count;
  // Head fields read as zero whenever nothing is queued.
  assign {bus.dm_addr_out, bus.dm_data_out, bus.dm_wr_mask_out} =
    empty ? '0 : head_entry;

endmodule
